wb_trace_buffer: RTL and testbench

Commit-trace capture buffer sitting directly downstream of the CPU core's write-back debug ports. Every cycle in which the core reports a retired instruction, the block packs the write-back PC, destination register, enable and value into one record. It queues the record in a DEPTH-entry FIFO and presents it on a valid/ready drain port for a UART/JTAG trace streamer or a testbench scoreboard. It also keeps a retired-instruction counter and a saturating drop counter so that lost records are visible.

---
 rtl/wb_trace_buffer.sv | 96 +++++++++
 tb/tb_wb_trace_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
// Commit-trace capture FIFO fed by the core's write-back debug ports, with retire/drop counters.
// Define WB_TRACE_FILTER_EN to queue only register-file writes to x1..x31.
module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             debug_wb_have_inst,
    input  logic [31:0]      debug_wb_pc,
    input  logic             debug_wb_ena,
    input  logic [4:0]       debug_wb_reg,
    input  logic [31:0]      debug_wb_value,
    input  logic             trace_clear,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [69:0]      trace_data,
    output logic [PTR_W:0]   trace_level,
    output logic             trace_full,
    output logic [31:0]      commit_count,
    output logic [15:0]      drop_count
);

    localparam logic [PTR_W:0]   FULL_LEVEL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   LEVEL_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [69:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   level;
    logic             cap;
    logic             pop;
    logic             push;
    logic             drop;
    logic [69:0]      record;

`ifdef WB_TRACE_FILTER_EN
    assign cap = debug_wb_have_inst && debug_wb_ena && (debug_wb_reg != 5'd0);
`else
    assign cap = debug_wb_have_inst;
`endif

    assign record      = {debug_wb_ena, debug_wb_reg, debug_wb_pc, debug_wb_value};
    assign trace_valid = (level != '0);
    assign trace_full  = (level == FULL_LEVEL);
    assign trace_level = level;
    assign trace_data  = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a capture at full is still accepted.
    assign pop  = trace_valid && trace_ready;
    assign push = cap && (!trace_full || pop);
    assign drop = cap && trace_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            commit_count <= '0;
            drop_count   <= '0;
        end else if (trace_clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            commit_count <= '0;
            drop_count   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                level <= level + LEVEL_ONE;
            end else if (pop && !push) begin
                level <= level - LEVEL_ONE;
            end
            if (debug_wb_have_inst) begin
                commit_count <= commit_count + 32'd1;
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Storage needs no reset; entries are only observed once the level covers them.
    always_ff @(posedge clk) begin
        if (push && !trace_clear) begin
            mem[wr_ptr] <= record;
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: table-driven vectors plus directed multi-cycle sequences.
// Filter test expectations follow WB_TRACE_FILTER_EN when it is defined for the build.
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             debug_wb_have_inst;
    logic [31:0]      debug_wb_pc;
    logic             debug_wb_ena;
    logic [4:0]       debug_wb_reg;
    logic [31:0]      debug_wb_value;
    logic             trace_clear;
    logic             trace_valid;
    logic             trace_ready;
    logic [69:0]      trace_data;
    logic [PTR_W:0]   trace_level;
    logic             trace_full;
    logic [31:0]      commit_count;
    logic [15:0]      drop_count;

    int checks = 0;
    int errors = 0;

    logic [69:0] exp_q[$];

    typedef struct {
        logic        have;
        logic [31:0] pc;
        logic        ena;
        logic [4:0]  rg;
        logic [31:0] value;
        logic        ready;
        logic        clear;
        logic        exp_valid;
        logic [69:0] exp_data;
        logic [4:0]  exp_level;
        logic        exp_full;
        logic [31:0] exp_commit;
        logic [15:0] exp_drop;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    wb_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .debug_wb_have_inst (debug_wb_have_inst),
        .debug_wb_pc        (debug_wb_pc),
        .debug_wb_ena       (debug_wb_ena),
        .debug_wb_reg       (debug_wb_reg),
        .debug_wb_value     (debug_wb_value),
        .trace_clear        (trace_clear),
        .trace_valid        (trace_valid),
        .trace_ready        (trace_ready),
        .trace_data         (trace_data),
        .trace_level        (trace_level),
        .trace_full         (trace_full),
        .commit_count       (commit_count),
        .drop_count         (drop_count)
    );

    function automatic logic [69:0] rec(input logic ena, input logic [4:0] rg,
                                        input logic [31:0] pc, input logic [31:0] value);
        return {ena, rg, pc, value};
    endfunction

    task automatic applyStimulus(input logic have, input logic [31:0] pc, input logic ena,
                                 input logic [4:0] rg, input logic [31:0] value,
                                 input logic ready, input logic clear);
        debug_wb_have_inst = have;
        debug_wb_pc        = pc;
        debug_wb_ena       = ena;
        debug_wb_reg       = rg;
        debug_wb_value     = value;
        trace_ready        = ready;
        trace_clear        = clear;
    endtask

    task automatic checkOutput(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Captures one record with ready low and records it in the expected queue.
    task automatic capture(input logic [31:0] pc, input logic [4:0] rg, input logic [31:0] value);
        applyStimulus(1'b1, pc, 1'b1, rg, value, 1'b0, 1'b0);
        exp_q.push_back(rec(1'b1, rg, pc, value));
        tick();
    endtask

    task automatic drainCheck(input string name, input int budget);
        applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            if (trace_valid) begin
                checkOutput($sformatf("%s data", name), trace_data, exp_q.pop_front());
            end
            tick();
        end
        checkOutput($sformatf("%s leftover", name), 70'(exp_q.size()), 70'd0);
        checkOutput($sformatf("%s level", name), 70'(trace_level), 70'd0);
        exp_q.delete();
        applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h10, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0,
                    1'b1, rec(1'b1, 5'd5, 32'h10, 32'hDEADBEEF), 5'd1, 1'b0, 32'd1, 16'd0};
        vecs[1] = '{1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                    1'b1, rec(1'b1, 5'd5, 32'h10, 32'hDEADBEEF), 5'd1, 1'b0, 32'd1, 16'd0};
        vecs[2] = '{1'b1, 32'h14, 1'b1, 5'd3, 32'h12345678, 1'b1, 1'b0,
                    1'b1, rec(1'b1, 5'd3, 32'h14, 32'h12345678), 5'd1, 1'b0, 32'd2, 16'd0};
        vecs[3] = '{1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0,
                    1'b0, '0, 5'd0, 1'b0, 32'd2, 16'd0};
        vecs[4] = '{1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0,
                    1'b0, '0, 5'd0, 1'b0, 32'd2, 16'd0};
        vecs[5] = '{1'b1, 32'h18, 1'b1, 5'd9, 32'h1, 1'b1, 1'b0,
                    1'b1, rec(1'b1, 5'd9, 32'h18, 32'h1), 5'd1, 1'b0, 32'd3, 16'd0};
        vecs[6] = '{1'b1, 32'h1C, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0,
                    1'b1, rec(1'b1, 5'd9, 32'h18, 32'h1), 5'd2, 1'b0, 32'd4, 16'd0};
        vecs[7] = '{1'b1, 32'h20, 1'b1, 5'd2, 32'h2, 1'b1, 1'b1,
                    1'b0, '0, 5'd0, 1'b0, 32'd0, 16'd0};
        vecs[8] = '{1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                    1'b0, '0, 5'd0, 1'b0, 32'd0, 16'd0};
        vecs[9] = '{1'b1, 32'h24, 1'b1, 5'd1, 32'hAA, 1'b0, 1'b0,
                    1'b1, rec(1'b1, 5'd1, 32'h24, 32'hAA), 5'd1, 1'b0, 32'd1, 16'd0};

        doReset();
        checkOutput("reset valid", 70'(trace_valid), 70'd0);
        checkOutput("reset level", 70'(trace_level), 70'd0);
        checkOutput("reset full", 70'(trace_full), 70'd0);
        checkOutput("reset commit", 70'(commit_count), 70'd0);
        checkOutput("reset drop", 70'(drop_count), 70'd0);

        // Table vectors: inputs held across one edge, outputs sampled just after it.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].have, vecs[i].pc, vecs[i].ena, vecs[i].rg, vecs[i].value,
                          vecs[i].ready, vecs[i].clear);
            tick();
            checkOutput($sformatf("vec%0d valid", i), 70'(trace_valid), 70'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d level", i), 70'(trace_level), 70'(vecs[i].exp_level));
            checkOutput($sformatf("vec%0d full", i), 70'(trace_full), 70'(vecs[i].exp_full));
            checkOutput($sformatf("vec%0d commit", i), 70'(commit_count), 70'(vecs[i].exp_commit));
            checkOutput($sformatf("vec%0d drop", i), 70'(drop_count), 70'(vecs[i].exp_drop));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d data", i), trace_data, vecs[i].exp_data);
            end
        end

        // Overflow: fill, drop three, then push+pop at full.
        $display("[TB] overflow sequence");
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            capture(32'h100 + 32'(4 * i), 5'((i % 31) + 1), 32'hA000_0000 + 32'(i));
        end
        checkOutput("fill full", 70'(trace_full), 70'd1);
        checkOutput("fill level", 70'(trace_level), 70'd16);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(4 * i), 1'b1, 5'd4, 32'hBAD0_0000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        checkOutput("ovf full", 70'(trace_full), 70'd1);
        checkOutput("ovf level", 70'(trace_level), 70'd16);
        checkOutput("ovf drop", 70'(drop_count), 70'd3);
        checkOutput("ovf commit", 70'(commit_count), 70'd19);
        applyStimulus(1'b1, 32'h300, 1'b1, 5'd7, 32'hCAFE_0000, 1'b1, 1'b0);
        checkOutput("full pp head", trace_data, exp_q.pop_front());
        exp_q.push_back(rec(1'b1, 5'd7, 32'h300, 32'hCAFE_0000));
        tick();
        checkOutput("full pp level", 70'(trace_level), 70'd16);
        checkOutput("full pp full", 70'(trace_full), 70'd1);
        checkOutput("full pp drop", 70'(drop_count), 70'd3);
        checkOutput("full pp commit", 70'(commit_count), 70'd20);
        drainCheck("ovf drain", 40);

        // Streaming: capture and consume every cycle, pointers wrap twice.
        $display("[TB] streaming sequence");
        doReset();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 32'h400 + 32'(4 * i), 1'b1, 5'((i % 31) + 1), 32'h5000 + 32'(i), 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("stream%0d level", i), 70'(trace_level), 70'd1);
            checkOutput($sformatf("stream%0d data", i), trace_data,
                        rec(1'b1, 5'((i % 31) + 1), 32'h400 + 32'(4 * i), 32'h5000 + 32'(i)));
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("stream end valid", 70'(trace_valid), 70'd0);
        checkOutput("stream end level", 70'(trace_level), 70'd0);
        checkOutput("stream end drop", 70'(drop_count), 70'd0);
        checkOutput("stream end commit", 70'(commit_count), 70'd40);

        // Clear beats a simultaneous capture.
        $display("[TB] clear sequence");
        doReset();
        for (int i = 0; i < 7; i++) begin
            capture(32'h600 + 32'(4 * i), 5'd6, 32'(i));
        end
        checkOutput("clear pre level", 70'(trace_level), 70'd7);
        applyStimulus(1'b1, 32'h700, 1'b1, 5'd8, 32'h77, 1'b1, 1'b1);
        tick();
        checkOutput("clear level", 70'(trace_level), 70'd0);
        checkOutput("clear valid", 70'(trace_valid), 70'd0);
        checkOutput("clear commit", 70'(commit_count), 70'd0);
        checkOutput("clear drop", 70'(drop_count), 70'd0);
        exp_q.delete();

        // Asynchronous reset between edges while draining.
        $display("[TB] async reset sequence");
        doReset();
        for (int i = 0; i < 3; i++) begin
            capture(32'h800 + 32'(4 * i), 5'd10, 32'h80 + 32'(i));
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("arst pre level", 70'(trace_level), 70'd2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst valid", 70'(trace_valid), 70'd0);
        checkOutput("arst level", 70'(trace_level), 70'd0);
        checkOutput("arst commit", 70'(commit_count), 70'd0);
        exp_q.delete();
        applyStimulus(1'b1, 32'h900, 1'b1, 5'd11, 32'h1234, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        tick();
        checkOutput("arst first level", 70'(trace_level), 70'd1);
        checkOutput("arst first commit", 70'(commit_count), 70'd1);
        checkOutput("arst first data", trace_data, rec(1'b1, 5'd11, 32'h900, 32'h1234));

        // Store, x0 write and x7 write.
        $display("[TB] filter sequence");
        doReset();
        applyStimulus(1'b1, 32'hA00, 1'b0, 5'd4, 32'h1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hA04, 1'b1, 5'd0, 32'h2, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hA08, 1'b1, 5'd7, 32'h3, 1'b0, 1'b0);
        tick();
`ifndef WB_TRACE_FILTER_EN
        exp_q.push_back(rec(1'b0, 5'd4, 32'hA00, 32'h1));
        exp_q.push_back(rec(1'b1, 5'd0, 32'hA04, 32'h2));
`endif
        exp_q.push_back(rec(1'b1, 5'd7, 32'hA08, 32'h3));
        checkOutput("filter commit", 70'(commit_count), 70'd3);
        checkOutput("filter level", 70'(trace_level), 70'(exp_q.size()));
        drainCheck("filter drain", 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
